// File: rtl/elastic_fill_monitor.sv
// Fill-level monitor for the RX elastic buffer: Gray pointers -> binary -> occupancy,
// sticky full/empty flags, and a hysteresis FSM issuing one SKP add/delete request at a time.
module elastic_fill_monitor #(
    parameter int BUFFER_DEPTH = 16,
    parameter int HIGH_WM      = 12,
    parameter int LOW_WM       = 4,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [$clog2(BUFFER_DEPTH):0]   gray_read_pointer,
    input  logic [$clog2(BUFFER_DEPTH):0]   gray_write_pointer,
    input  logic                            skp_ack,
    input  logic                            err_clr,
    output logic [$clog2(BUFFER_DEPTH):0]   fill_level,
    output logic                            delete_req,
    output logic                            add_req,
    output logic                            full_err,
    output logic                            empty_err
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(GUARD_CYCLES + 1);

    localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
    localparam logic [PW-1:0] HIGH_P  = PW'(HIGH_WM);
    localparam logic [PW-1:0] LOW_P   = PW'(LOW_WM);
    localparam logic [CW-1:0] GUARD_P = CW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEL   = 2'd1,
        S_ADD   = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_rd_bin;
    logic [PW-1:0] r_fill;
    logic          r_full_err;
    logic          r_empty_err;
    state_t        r_state;
    logic [CW-1:0] r_guard_cnt;
    logic          r_del_req;
    logic          r_add_req;

    logic [PW-1:0] w_diff;
    logic          w_diff_ok;

    // Modular subtract handles the pointer wrap; anything above DEPTH is an illegal pointer pair.
    assign w_diff    = r_wr_bin - r_rd_bin;
    assign w_diff_ok = (w_diff <= DEPTH_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bin <= '0;
            r_rd_bin <= '0;
            r_fill   <= '0;
        end else begin
            r_wr_bin <= gray2bin(gray_write_pointer);
            r_rd_bin <= gray2bin(gray_read_pointer);
            r_fill   <= w_diff_ok ? w_diff : DEPTH_P;
        end
    end

    // Sticky flags: a new set condition outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_err  <= 1'b0;
            r_empty_err <= 1'b0;
        end else begin
            r_full_err  <= (r_fill == DEPTH_P) | (r_full_err & ~err_clr);
            r_empty_err <= ((r_fill == '0) & enable) | (r_empty_err & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_guard_cnt <= '0;
            r_del_req   <= 1'b0;
            r_add_req   <= 1'b0;
        end else if (!enable) begin
            r_state     <= S_IDLE;
            r_guard_cnt <= '0;
            r_del_req   <= 1'b0;
            r_add_req   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_fill >= HIGH_P) begin
                        r_state   <= S_DEL;
                        r_del_req <= 1'b1;
                    end else if (r_fill <= LOW_P) begin
                        r_state   <= S_ADD;
                        r_add_req <= 1'b1;
                    end
                end
                S_DEL, S_ADD: begin
                    // Request is held regardless of fill until the buffer control acknowledges it.
                    if (skp_ack) begin
                        r_state     <= S_GUARD;
                        r_guard_cnt <= GUARD_P;
                        r_del_req   <= 1'b0;
                        r_add_req   <= 1'b0;
                    end
                end
                S_GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_guard_cnt <= '0;
                    r_del_req   <= 1'b0;
                    r_add_req   <= 1'b0;
                end
            endcase
        end
    end

    assign fill_level = r_fill;
    assign delete_req = r_del_req;
    assign add_req    = r_add_req;
    assign full_err   = r_full_err;
    assign empty_err  = r_empty_err;

endmodule

// File: tb/tb_elastic_fill_monitor.sv
// Directed bench for elastic_fill_monitor: an integer-level occupancy/request model checked
// every cycle, plus hand-computed checkpoints along the stimulus sequence.
module tb_elastic_fill_monitor;

    localparam int DEPTH = 16;
    localparam int HIGH  = 12;
    localparam int LOW   = 4;
    localparam int GUARD = 4;
    localparam int PW    = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [PW-1:0] gray_read_pointer;
    logic [PW-1:0] gray_write_pointer;
    logic          skp_ack;
    logic          err_clr;
    logic [PW-1:0] fill_level;
    logic          delete_req;
    logic          add_req;
    logic          full_err;
    logic          empty_err;

    int n_cmp;
    int n_bad;
    int wr_b;
    int rd_b;

    elastic_fill_monitor #(
        .BUFFER_DEPTH(DEPTH), .HIGH_WM(HIGH), .LOW_WM(LOW), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .gray_read_pointer(gray_read_pointer), .gray_write_pointer(gray_write_pointer),
        .skp_ack(skp_ack), .err_clr(err_clr),
        .fill_level(fill_level), .delete_req(delete_req), .add_req(add_req),
        .full_err(full_err), .empty_err(empty_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = b[PW-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic ptr(input int w, input int r);
        wr_b = w;
        rd_b = r;
        gray_write_pointer = to_gray(w);
        gray_read_pointer  = to_gray(r);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: occupancy is (wr - rd) mod 32, saturated, visible two edges after the pointers;
    // requests: at most one outstanding, then GUARD quiet edges after each acknowledge.
    int m_s1w, m_s1r, m_fill, m_mode, m_quiet, m_d;
    bit m_full, m_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1w = 0; m_s1r = 0; m_fill = 0; m_mode = 0; m_quiet = 0;
            m_full = 0; m_empty = 0;
        end else begin
            m_d = (((m_s1w - m_s1r) % 32) + 32) % 32;
            m_full  = (m_fill == DEPTH) || (m_full && !err_clr);
            m_empty = (m_fill == 0 && enable) || (m_empty && !err_clr);
            if (!enable) begin
                m_mode = 0;
                m_quiet = 0;
            end else if (m_mode != 0) begin
                if (skp_ack) begin
                    m_mode = 0;
                    m_quiet = GUARD;
                end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if (m_fill >= HIGH) begin
                m_mode = 1;
            end else if (m_fill <= LOW) begin
                m_mode = 2;
            end
            m_fill = (m_d > DEPTH) ? DEPTH : m_d;
            m_s1w = wr_b;
            m_s1r = rd_b;
        end
    end

    always @(negedge clk) begin
        chk("m_fill",  fill_level, m_fill);
        chk("m_del",   delete_req, m_mode == 1);
        chk("m_add",   add_req,    m_mode == 2);
        chk("m_full",  full_err,   m_full);
        chk("m_empty", empty_err,  m_empty);
        chk("m_excl",  delete_req & add_req, 0);
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; enable = 1'b1; skp_ack = 1'b0; err_clr = 1'b0;
        ptr(9, 3);
        #2;
        chk("rst_fill", fill_level, 0);
        chk("rst_del",  delete_req, 0);
        chk("rst_add",  add_req, 0);
        chk("rst_full", full_err, 0);
        chk("rst_empty", empty_err, 0);
        tick(2);

        // Reset release, equal pointers: empty buffer -> add request
        rst_n = 1'b1;
        ptr(5, 5);
        tick(3);
        chk("a_fill0", fill_level, 0);
        chk("a_empty", empty_err, 1);
        chk("a_add",   add_req, 1);

        // Ack the add, settle into the hysteresis band at fill 8, clear empty
        skp_ack = 1'b1; ptr(13, 5);
        tick();
        skp_ack = 1'b0;
        chk("b_add_drop", add_req, 0);
        tick(6);
        chk("b_band_del", delete_req, 0);
        chk("b_band_add", add_req, 0);
        chk("b_empty_sticky", empty_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("b_empty_clr", empty_err, 0);

        // Delete path with guard interval
        ptr(17, 5);
        tick(2);
        chk("c_fill12", fill_level, 12);
        chk("c_del_lat", delete_req, 0);
        tick();
        chk("c_del", delete_req, 1);
        tick(3);
        chk("c_del_hold", delete_req, 1);
        skp_ack = 1'b1;
        tick();
        skp_ack = 1'b0;
        chk("c_del_drop", delete_req, 0);
        for (int i = 0; i < GUARD; i++) begin
            tick();
            chk("c_guard", delete_req, 0);
        end
        tick();
        chk("c_del_again", delete_req, 1);

        // Enable drop while requesting, then re-enable at fill 13
        enable = 1'b0;
        tick();
        chk("d_dis_drop", delete_req, 0);
        ptr(18, 5);
        tick(3);
        chk("d_dis_fill", fill_level, 13);
        chk("d_dis_quiet", delete_req, 0);
        enable = 1'b1;
        tick();
        chk("d_reen", delete_req, 1);

        // Hysteresis sweep downwards: no request until fill reaches LOW
        skp_ack = 1'b1; ptr(13, 5);
        tick();
        skp_ack = 1'b0;
        for (int f = 8; f >= 5; f--) begin
            ptr(5 + f, 5);
            tick(3);
            chk("e_sweep_del", delete_req, 0);
            chk("e_sweep_add", add_req, 0);
        end
        ptr(9, 5);
        tick(2);
        chk("e_add_lat", add_req, 0);
        tick();
        chk("e_add", add_req, 1);
        ptr(14, 5);
        tick(5);
        chk("e_fill9", fill_level, 9);
        chk("e_add_hold", add_req, 1);
        skp_ack = 1'b1;
        tick();
        skp_ack = 1'b0;
        chk("e_add_drop", add_req, 0);

        // Wrap-around: rd 30, wr 3 -> 5 entries
        ptr(3, 30);
        tick(3);
        chk("f_wrap_fill", fill_level, 5);
        chk("f_wrap_full", full_err, 0);
        tick(6);
        chk("f_wrap_del", delete_req, 0);
        chk("f_wrap_add", add_req, 0);

        // Illegal pointer difference saturates and sets full; clear only once it goes away
        ptr(20, 0);
        tick(2);
        chk("g_sat_fill", fill_level, 16);
        tick();
        chk("g_full", full_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("g_full_set_wins", full_err, 1);
        ptr(8, 0);
        tick(3);
        chk("g_fill8", fill_level, 8);
        chk("g_full_sticky", full_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("g_full_clr", full_err, 0);

        // Exactly DEPTH entries is legal but still flags full
        ptr(16, 0);
        tick(3);
        chk("g_exact_fill", fill_level, 16);
        chk("g_exact_full", full_err, 1);
        chk("g_exact_del", delete_req, 1);

        // Asynchronous reset mid-request
        #2;
        rst_n = 1'b0;
        #1;
        chk("h_rst_del", delete_req, 0);
        chk("h_rst_fill", fill_level, 0);
        chk("h_rst_full", full_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
